// File: rtl/banda_pkg.sv
// Shared types for the assembly-line datapath stages.
// Sequencer state encoding and default word width.
package banda_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int WIDTH_DEF = 8;

endpackage

// File: rtl/bloc.sv
// Existing 1-bit XOR cell of the assembly line.
// Purely combinational, no register stage.
module bloc (
  input  logic a,
  input  logic b,
  output logic c
);

  assign c = a ^ b;

endmodule

// File: rtl/banda_xor_seq.sv
// Bit-serial sequencer feeding the external XOR cell LSB-first
// and reassembling its output into a word with running parity.
module banda_xor_seq
  import banda_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             bit_a,
  output logic             bit_b,
  input  logic             bit_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_parity,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             par_q, par_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      par_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      res_q   <= res_d;
      par_q   <= par_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    res_d   = res_q;
    par_d   = par_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sa_d    = in_a;
          sb_d    = in_b;
          res_d   = '0;
          par_d   = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        res_d = {bit_c, res_q[WIDTH-1:1]};
        par_d = par_q ^ bit_c;
        // Counter parks at LAST so it never wraps.
        if (cnt_q == LAST) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign bit_a      = (state_q == SHIFT) & sa_q[0];
  assign bit_b      = (state_q == SHIFT) & sb_q[0];
  assign out_data   = res_q;
  assign out_parity = par_q;

endmodule

// File: tb/tb_banda_xor_seq.sv
// Directed bench for the bit-serial XOR sequencer with the
// external XOR cell wired in as on the assembly line.
module tb_banda_xor_seq;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       bit_a;
  logic       bit_b;
  logic       bit_c;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_parity;
  logic       busy;

  int n_chk;
  int n_fail;

  banda_xor_seq #(.WIDTH(8)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .bit_a     (bit_a),
    .bit_b     (bit_b),
    .bit_c     (bit_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_parity(out_parity),
    .busy      (busy)
  );

  bloc u_bloc (
    .a(bit_a),
    .b(bit_b),
    .c(bit_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    chk("send_rdy", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat, output logic [7:0] bits);
    lat  = 1;
    bits = '0;
    while (!out_valid && lat < 20) begin
      if (lat <= 8) bits[lat-1] = bit_a;
      tick();
      lat++;
    end
  endtask

  task automatic ack;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic word(
    input string      tag,
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [7:0] d,
    input logic       p
  );
    int         lat;
    logic [7:0] bits;
    send(a, b);
    wait_done(lat, bits);
    chk({tag, "_lat"}, 32'(lat), 32'd9);
    chk({tag, "_data"}, 32'(out_data), 32'(d));
    chk({tag, "_par"}, 32'(out_parity), 32'(p));
    ack();
    chk({tag, "_idle"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int         lat;
    int         nv;
    int         acc_n;
    int         res_n;
    int         acc_t[2];
    logic [7:0] res_d[2];
    logic       res_p[2];
    logic [7:0] bits;

    n_chk     = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;

    @(negedge clk);
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'h00);
    chk("rst_parity", 32'(out_parity), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_bits", 32'({bit_a, bit_b}), 32'd0);

    send(8'hA5, 8'h3C);
    wait_done(lat, bits);
    chk("basic_lat", 32'(lat), 32'd9);
    chk("basic_bit_a", 32'(bits), 32'hA5);
    chk("basic_data", 32'(out_data), 32'h99);
    chk("basic_par", 32'(out_parity), 32'd0);
    chk("basic_bits_done", 32'({bit_a, bit_b}), 32'd0);
    ack();

    word("ff_ff", 8'hFF, 8'hFF, 8'h00, 1'b0);
    word("ff_00", 8'hFF, 8'h00, 8'hFF, 1'b0);
    word("01_00", 8'h01, 8'h00, 8'h01, 1'b1);

    send(8'hC3, 8'h0F);
    wait_done(lat, bits);
    chk("bp_data0", 32'(out_data), 32'hCC);
    in_valid = 1'b1;
    in_a     = 8'h12;
    in_b     = 8'h34;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_hold", 32'(out_data), 32'hCC);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_ack_idle", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_accept", 32'(busy), 32'd1);
    wait_done(lat, bits);
    chk("bp_lat", 32'(lat), 32'd9);
    chk("bp_data1", 32'(out_data), 32'h26);
    chk("bp_par1", 32'(out_parity), 32'd1);
    ack();

    send(8'hAA, 8'h55);
    tick();
    tick();
    tick();
    chk("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_in_ready", 32'(in_ready), 32'd1);
    chk("mid_busy_lo", 32'(busy), 32'd0);
    chk("mid_data", 32'(out_data), 32'h00);
    nv = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) nv++;
      tick();
    end
    chk("mid_no_valid", 32'(nv), 32'd0);
    word("after_rst", 8'h0F, 8'hF0, 8'hFF, 1'b0);

    acc_n     = 0;
    res_n     = 0;
    in_valid  = 1'b1;
    in_a      = 8'h5A;
    in_b      = 8'h0F;
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (res_n == 2) break;
      if (in_valid && in_ready) begin
        acc_t[acc_n] = i;
        acc_n++;
      end
      if (out_valid && res_n < 2) begin
        res_d[res_n] = out_data;
        res_p[res_n] = out_parity;
        res_n++;
      end
      tick();
      if (acc_n == 1) begin
        in_a = 8'h81;
        in_b = 8'h7E;
      end
      if (acc_n == 2) in_valid = 1'b0;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("b2b_accepts", 32'(acc_n), 32'd2);
    chk("b2b_results", 32'(res_n), 32'd2);
    if (acc_n == 2) begin
      chk("b2b_gap", 32'(acc_t[1] - acc_t[0]), 32'd10);
    end
    if (res_n == 2) begin
      chk("b2b_data0", 32'(res_d[0]), 32'h55);
      chk("b2b_par0", 32'(res_p[0]), 32'd0);
      chk("b2b_data1", 32'(res_d[1]), 32'hFF);
      chk("b2b_par1", 32'(res_p[1]), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
